// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks a KxK window across a row-major image and emits
// one image-RAM read address per valid/ready transfer, tagging the first and
// last pixel of each window. Addresses are built from running base registers
// (row base, window base, pixel-row base) so no multipliers are needed.
//
// Handshake: addr_valid/addr/win_first/win_last/out_x/out_y form one beat; a
// beat transfers on a clock edge where addr_valid & addr_ready are both high.
// While addr_valid is high and addr_ready is low every field holds stable.
// addr_valid never drops inside a frame, so the next beat appears the cycle
// after each transfer.
module conv_window_scheduler #(
  parameter int IMG_W  = 96,
  parameter int IMG_H  = 96,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1,
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1,
  localparam int AW    = $clog2(IMG_W * IMG_H),
  localparam int OXW   = $clog2(OUT_W + 1),
  localparam int OYW   = $clog2(OUT_H + 1),
  localparam int KW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic           addr_ready,
  output logic           addr_valid,
  output logic [AW-1:0]  addr,
  output logic           win_first,
  output logic           win_last,
  output logic [OXW-1:0] out_x,
  output logic [OYW-1:0] out_y,
  output logic           busy,
  output logic           done,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [KW-1:0]  C_KMAX  = KW'(K - 1);
  localparam logic [OXW-1:0] C_OXMAX = OXW'(OUT_W - 1);
  localparam logic [OYW-1:0] C_OYMAX = OYW'(OUT_H - 1);
  localparam logic [AW-1:0]  C_W     = AW'(IMG_W);
  localparam logic [AW-1:0]  C_S     = AW'(STRIDE);
  localparam logic [AW-1:0]  C_SW    = AW'(STRIDE * IMG_W);
  localparam logic           C_K1    = (K == 1);

  state_t         r_state;
  logic [KW-1:0]  r_kx, r_ky;
  logic [OXW-1:0] r_ox;
  logic [OYW-1:0] r_oy;
  logic [AW-1:0]  r_row;   // address of pixel (oy*STRIDE, 0)
  logic [AW-1:0]  r_win;   // address of window top-left pixel
  logic [AW-1:0]  r_pix;   // address of (oy*STRIDE+ky, ox*STRIDE)
  logic [AW-1:0]  r_addr;
  logic           r_valid, r_first, r_last, r_busy, r_done;

  logic [KW-1:0]  w_nkx, w_nky;
  logic [OXW-1:0] w_nox;
  logic [OYW-1:0] w_noy;
  logic [AW-1:0]  w_nrow, w_nwin, w_npix, w_naddr;
  logic           w_nfirst, w_nlast, w_final, w_xfer;

  assign w_xfer  = r_valid && addr_ready;
  assign w_final = (r_kx == C_KMAX) && (r_ky == C_KMAX) &&
                   (r_ox == C_OXMAX) && (r_oy == C_OYMAX);

  // Next position in kx -> ky -> ox -> oy order, with addresses advanced by adds.
  always_comb begin
    w_nkx   = r_kx;
    w_nky   = r_ky;
    w_nox   = r_ox;
    w_noy   = r_oy;
    w_nrow  = r_row;
    w_nwin  = r_win;
    w_npix  = r_pix;
    w_naddr = r_addr;
    if (r_kx != C_KMAX) begin
      w_nkx   = r_kx + 1'b1;
      w_naddr = r_addr + 1'b1;
    end else begin
      w_nkx = '0;
      if (r_ky != C_KMAX) begin
        w_nky   = r_ky + 1'b1;
        w_npix  = r_pix + C_W;
        w_naddr = r_pix + C_W;
      end else begin
        w_nky = '0;
        if (r_ox != C_OXMAX) begin
          w_nox   = r_ox + 1'b1;
          w_nwin  = r_win + C_S;
          w_npix  = r_win + C_S;
          w_naddr = r_win + C_S;
        end else begin
          w_nox = '0;
          if (r_oy != C_OYMAX) begin
            w_noy   = r_oy + 1'b1;
            w_nrow  = r_row + C_SW;
            w_nwin  = r_row + C_SW;
            w_npix  = r_row + C_SW;
            w_naddr = r_row + C_SW;
          end
        end
      end
    end
    w_nfirst = (w_nkx == '0) && (w_nky == '0);
    w_nlast  = (w_nkx == C_KMAX) && (w_nky == C_KMAX);
  end

  // Control FSM with registered beat outputs; abort outranks a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_kx    <= '0;
      r_ky    <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_row   <= '0;
      r_win   <= '0;
      r_pix   <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_RUN;
            r_kx    <= '0;
            r_ky    <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_pix   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= C_K1;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort || (w_xfer && w_final)) begin
            r_state <= abort ? ST_IDLE : ST_DONE;
            r_done  <= !abort;
            r_kx    <= '0;
            r_ky    <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_pix   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            r_kx    <= w_nkx;
            r_ky    <= w_nky;
            r_ox    <= w_nox;
            r_oy    <= w_noy;
            r_row   <= w_nrow;
            r_win   <= w_nwin;
            r_pix   <= w_npix;
            r_addr  <= w_naddr;
            r_first <= w_nfirst;
            r_last  <= w_nlast;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_valid = r_valid;
  assign addr       = r_addr;
  assign win_first  = r_first;
  assign win_last   = r_last;
  assign out_x      = r_ox;
  assign out_y      = r_oy;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: three instances (4x4 K3 S1, 5x5 K3 S2,
// 3x3 K1 S1) share clock and reset; one is selected at a time. The driver
// pushes a reference address stream computed from the window formula; a
// negedge monitor checks every presented beat against the queue head.
module tb_conv_window_scheduler;

  localparam int EW = 34;

  localparam int AW0 = $clog2(4 * 4);
  localparam int XW0 = $clog2(2 + 1);
  localparam int AW1 = $clog2(5 * 5);
  localparam int XW1 = $clog2(2 + 1);
  localparam int AW2 = $clog2(3 * 3);
  localparam int XW2 = $clog2(3 + 1);

  int cfg_w [3] = '{4, 5, 3};
  int cfg_h [3] = '{4, 5, 3};
  int cfg_k [3] = '{3, 3, 1};
  int cfg_s [3] = '{1, 2, 1};

  logic clk;
  logic reset;
  logic [2:0] start_v, abort_v, ready_v;
  int sel;

  logic           valid0, first0, last0, busy0, done0;
  logic [AW0-1:0] addr0;
  logic [XW0-1:0] ox0, oy0;
  logic [1:0]     st0;
  logic           valid1, first1, last1, busy1, done1;
  logic [AW1-1:0] addr1;
  logic [XW1-1:0] ox1, oy1;
  logic [1:0]     st1;
  logic           valid2, first2, last2, busy2, done2;
  logic [AW2-1:0] addr2;
  logic [XW2-1:0] ox2, oy2;
  logic [1:0]     st2;

  logic        m_valid, m_first, m_last, m_busy, m_done, m_ready;
  logic [15:0] m_addr;
  logic [7:0]  m_ox, m_oy;

  logic [EW-1:0] exp_q[$];
  int  n_vec;
  int  n_fail;
  int  xfer_cnt;
  bit  frame_live;
  bit  exp_done;
  bit  done_seen;

  conv_window_scheduler #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .addr_ready(ready_v[0]), .addr_valid(valid0), .addr(addr0),
    .win_first(first0), .win_last(last0), .out_x(ox0), .out_y(oy0),
    .busy(busy0), .done(done0), .dbg_state(st0));

  conv_window_scheduler #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .addr_ready(ready_v[1]), .addr_valid(valid1), .addr(addr1),
    .win_first(first1), .win_last(last1), .out_x(ox1), .out_y(oy1),
    .busy(busy1), .done(done1), .dbg_state(st1));

  conv_window_scheduler #(.IMG_W(3), .IMG_H(3), .K(1), .STRIDE(1)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort_v[2]),
    .addr_ready(ready_v[2]), .addr_valid(valid2), .addr(addr2),
    .win_first(first2), .win_last(last2), .out_x(ox2), .out_y(oy2),
    .busy(busy2), .done(done2), .dbg_state(st2));

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // route the selected instance onto common observation signals
  always_comb begin
    m_valid = valid0; m_first = first0; m_last = last0; m_busy = busy0;
    m_done = done0; m_addr = 16'(addr0); m_ox = 8'(ox0); m_oy = 8'(oy0);
    m_ready = ready_v[0];
    if (sel == 1) begin
      m_valid = valid1; m_first = first1; m_last = last1; m_busy = busy1;
      m_done = done1; m_addr = 16'(addr1); m_ox = 8'(ox1); m_oy = 8'(oy1);
      m_ready = ready_v[1];
    end else if (sel == 2) begin
      m_valid = valid2; m_first = first2; m_last = last2; m_busy = busy2;
      m_done = done2; m_addr = 16'(addr2); m_ox = 8'(ox2); m_oy = 8'(oy2);
      m_ready = ready_v[2];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference stream: every window pixel in kx, ky, ox, oy order
  task automatic push_frame(input int c);
    int ow, oh, k, s, w;
    k  = cfg_k[c];
    s  = cfg_s[c];
    w  = cfg_w[c];
    ow = (cfg_w[c] - k) / s + 1;
    oh = (cfg_h[c] - k) / s + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            int a;
            bit f, l;
            a = (oy * s + ky) * w + ox * s + kx;
            f = (kx == 0) && (ky == 0);
            l = (kx == k - 1) && (ky == k - 1);
            exp_q.push_back({8'(oy), 8'(ox), f, l, 16'(a)});
          end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_done) begin
        check("done_pulse", 64'({m_done, m_valid, m_busy}), 64'(3'b100));
        exp_done  = 1'b0;
        done_seen = 1'b1;
      end else begin
        check("done_low", 64'(m_done), 64'd0);
        if (frame_live) begin
          check("valid_busy_run", 64'({m_valid, m_busy}), 64'(2'b11));
          if (m_valid) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_fail++;
              $display("FAIL extra_beat: got addr 0x%0h expected no beat", m_addr);
            end else begin
              check("beat", 64'({m_oy, m_ox, m_first, m_last, m_addr}), 64'(exp_q[0]));
              if (m_ready) begin
                void'(exp_q.pop_front());
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                  frame_live = 1'b0;
                  exp_done   = 1'b1;
                end
              end
            end
          end
        end else begin
          check("idle_quiet", 64'({m_valid, m_busy}), 64'd0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, 64'({m_valid, m_first, m_last, m_busy, m_done}), 64'd0);
    check({name, "_addr"}, 64'(m_addr), 64'd0);
    check({name, "_xy"}, 64'({m_ox, m_oy}), 64'd0);
  endtask

  // one frame on the selected instance; ready duty in percent
  task automatic run_frame(input int ready_pct, input int abort_after,
                           input int reset_after, input bit hold_start);
    int total;
    bit finished, aborted, was_reset;
    finished = 0; aborted = 0; was_reset = 0;
    xfer_cnt  = 0;
    done_seen = 1'b0;
    exp_done  = 1'b0;
    push_frame(sel);
    total = exp_q.size();
    start_v[sel] = 1'b1;
    ready_v[sel] = ($urandom_range(0, 99) < ready_pct);
    @(posedge clk); #1;
    frame_live = 1'b1;
    if (!hold_start) start_v[sel] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done_seen) begin
        finished = 1;
        break;
      end
      if (abort_after >= 0 && xfer_cnt == abort_after) begin
        abort_v[sel] = 1'b1;
        ready_v[sel] = 1'b0;
        @(posedge clk); #1;
        abort_v[sel] = 1'b0;
        start_v[sel] = 1'b0;
        frame_live = 1'b0;
        exp_q.delete();
        aborted = 1;
        break;
      end
      if (reset_after >= 0 && xfer_cnt == reset_after) begin
        reset = 1'b1;
        ready_v[sel] = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("mid_reset");
        frame_live = 1'b0;
        exp_q.delete();
        start_v[sel] = 1'b0;
        reset = 1'b0;
        was_reset = 1;
        break;
      end
      ready_v[sel] = ($urandom_range(0, 99) < ready_pct);
      @(posedge clk); #1;
    end
    start_v[sel] = 1'b0;
    ready_v[sel] = 1'b0;
    if (finished) begin
      check("xfer_count", 64'(xfer_cnt), 64'(total));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
    end else if (aborted) begin
      check("abort_count", 64'(xfer_cnt), 64'(abort_after));
    end else if (was_reset) begin
      check("reset_count", 64'(xfer_cnt), 64'(reset_after));
    end else begin
      n_vec++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d transfers expected %0d", xfer_cnt, total);
      frame_live = 1'b0;
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    if (aborted || was_reset) check("no_done_after_cancel", 64'(done_seen), 64'd0);
    if (hold_start) check("no_restart_count", 64'(xfer_cnt), 64'(total));
  endtask

  // stimulus
  initial begin
    n_vec = 0; n_fail = 0; xfer_cnt = 0;
    frame_live = 0; exp_done = 0; done_seen = 0;
    reset = 1'b1; start_v = '0; abort_v = '0; ready_v = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check_reset_outputs("reset_state");
    end
    sel = 0;
    reset = 1'b0;
    @(posedge clk); #1;

    run_frame(100, -1, -1, 1'b0);   // 4x4 K3 S1 full rate
    run_frame(50, -1, -1, 1'b0);    // backpressure
    run_frame(30, -1, -1, 1'b0);    // heavy backpressure
    run_frame(100, 7, -1, 1'b0);    // abort mid-window
    run_frame(70, -1, -1, 1'b0);    // restart from addr 0
    run_frame(100, -1, -1, 1'b1);   // start held in RUN and DONE
    run_frame(60, -1, 10, 1'b0);    // reset mid-frame
    run_frame(100, -1, -1, 1'b0);

    sel = 1;
    run_frame(100, -1, -1, 1'b0);   // 5x5 K3 S2
    run_frame(50, -1, -1, 1'b0);

    sel = 2;
    run_frame(100, -1, -1, 1'b0);   // 3x3 K1
    run_frame(40, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
